// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-bit indices, default widths and payload type for pipeline stage registers
package pipe_pkg;
   localparam int CTRL_WREG  = 0;
   localparam int CTRL_M2REG = 1;
   localparam int CTRL_WMEM  = 2;
   localparam int DW_DEF     = 32;
   localparam int RW_DEF     = 5;
   localparam int CW_DEF     = 3;
   localparam int SCW_DEF    = 16;
   typedef struct packed {
      logic [CW_DEF-1:0] ctrl;
      logic [DW_DEF-1:0] alu;
      logic [DW_DEF-1:0] b;
      logic [RW_DEF-1:0] rn;
   } pipe_payload_t;
endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one payload entry with valid bit; flush drops the entry and its ctrl bits (low CW bits) but keeps data
module pipe_slot #(
   parameter int PW = 8,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          flush_i,
   input  logic          load_i,
   input  logic          clear_i,
   input  logic [PW-1:0] d_i,
   output logic          valid_o,
   output logic [PW-1:0] q_o
);
   logic          valid_q, valid_d;
   logic [PW-1:0] data_q, data_d;
   always_comb begin
      valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : clear_i ? 1'b0 : valid_q;
      data_d  = flush_i ? {data_q[PW-1:CW], {CW{1'b0}}} : load_i ? d_i : data_q;
   end
   always_ff @(posedge clk) begin
      if (!clrn) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end
   assign valid_o = valid_q;
   assign q_o     = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register with flush, bubble gating and stall counter; PIPE_STAGE_SKID_EN adds a skid entry
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int RW  = RW_DEF,
   parameter int CW  = CW_DEF,
   parameter int SCW = SCW_DEF
) (
   input  logic           clk,
   input  logic           clrn,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [CW-1:0]  in_ctrl,
   input  logic [DW-1:0]  in_alu,
   input  logic [DW-1:0]  in_b,
   input  logic [RW-1:0]  in_rn,
   input  logic           flush,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [CW-1:0]  out_ctrl,
   output logic [DW-1:0]  out_alu,
   output logic [DW-1:0]  out_b,
   output logic [RW-1:0]  out_rn,
   output logic [SCW-1:0] stall_cnt
);
   localparam int PW = 2*DW + RW + CW;
   logic [PW-1:0]  in_pl, main_d, main_q;
   logic           main_v, main_ld, in_xfer, out_xfer;
   logic [SCW-1:0] stall_q, stall_d;
   assign in_pl    = {in_alu, in_b, in_rn, in_ctrl};
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = main_v && out_ready;
`ifdef PIPE_STAGE_SKID_EN
   logic [PW-1:0] skid_q;
   logic          skid_v;
   // skid only fills when main is held; it always drains into main first to keep order
   assign in_ready = !skid_v;
   assign main_ld  = (skid_v && out_xfer) || (in_xfer && (!main_v || out_xfer));
   assign main_d   = skid_v ? skid_q : in_pl;
   pipe_slot #(.PW(PW), .CW(CW)) u_skid (
      .clk(clk), .clrn(clrn), .flush_i(flush),
      .load_i(in_xfer && main_v && !out_xfer), .clear_i(out_xfer),
      .d_i(in_pl), .valid_o(skid_v), .q_o(skid_q)
   );
`else
   assign in_ready = !main_v || out_ready;
   assign main_ld  = in_xfer;
   assign main_d   = in_pl;
`endif
   pipe_slot #(.PW(PW), .CW(CW)) u_main (
      .clk(clk), .clrn(clrn), .flush_i(flush),
      .load_i(main_ld), .clear_i(out_xfer),
      .d_i(main_d), .valid_o(main_v), .q_o(main_q)
   );
   assign out_valid = main_v;
   assign {out_alu, out_b, out_rn} = main_q[PW-1:CW];
   assign out_ctrl  = main_q[CW-1:0] & {CW{main_v}};
   always_comb stall_d = (main_v && !out_ready && stall_q != {SCW{1'b1}}) ? stall_q + 1'b1 : stall_q;
   always_ff @(posedge clk) begin
      if (!clrn) stall_q <= '0;
      else stall_q <= stall_d;
   end
   assign stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: table-driven stream with payload scoreboard plus directed reset/stall/flush/skid sequences
module tb_pipe_stage_reg;
   import pipe_pkg::*;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif
   logic        clk = 1'b0, clrn = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [2:0]  in_ctrl = '0;
   logic [31:0] in_alu = '0, in_b = '0;
   logic [4:0]  in_rn = '0;
   logic        in_ready, out_valid, in_ready2, out_valid2;
   logic [2:0]  out_ctrl, out_ctrl2;
   logic [31:0] out_alu, out_b, out_alu2, out_b2;
   logic [4:0]  out_rn, out_rn2;
   logic [15:0] stall_cnt;
   logic [1:0]  stall_cnt2;
   int n_cmp = 0, n_err = 0;
   pipe_payload_t sb[$];
   pipe_payload_t p;
   typedef struct {
      logic iv; logic [2:0] ctrl; logic [31:0] alu; logic [31:0] b; logic [4:0] rn; logic ordy;
      logic exp_rdy; logic exp_ov; logic [2:0] exp_ctrl; logic [31:0] exp_alu; logic chk_alu;
   } vec_t;
   vec_t tbl[9];
   always #5 clk = ~clk;
   pipe_stage_reg dut (
      .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
      .in_alu(in_alu), .in_b(in_b), .in_rn(in_rn), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_ctrl(out_ctrl), .out_alu(out_alu), .out_b(out_b),
      .out_rn(out_rn), .stall_cnt(stall_cnt)
   );
   pipe_stage_reg #(.SCW(2)) dut2 (
      .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready2), .in_ctrl(in_ctrl),
      .in_alu(in_alu), .in_b(in_b), .in_rn(in_rn), .flush(flush), .out_valid(out_valid2),
      .out_ready(out_ready), .out_ctrl(out_ctrl2), .out_alu(out_alu2), .out_b(out_b2),
      .out_rn(out_rn2), .stall_cnt(stall_cnt2)
   );
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic iv, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic ordy);
      in_valid = iv; in_ctrl = c; in_alu = a; in_b = b; in_rn = r; out_ready = ordy;
   endtask
   initial begin
      tbl[0] = '{1'b1, 3'd1, 32'h11, 32'h100, 5'd1, 1'b1, 1'b1, 1'b1, 3'd1, 32'h11, 1'b1};
      tbl[1] = '{1'b1, 3'd3, 32'h22, 32'h200, 5'd2, 1'b1, 1'b1, 1'b1, 3'd3, 32'h22, 1'b1};
      tbl[2] = '{1'b1, 3'd5, 32'h33, 32'h300, 5'd3, 1'b1, 1'b1, 1'b1, 3'd5, 32'h33, 1'b1};
      tbl[3] = '{1'b0, 3'd7, 32'hdead, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0};
      tbl[4] = '{1'b1, 3'd4, 32'h44, 32'h400, 5'd4, 1'b1, 1'b1, 1'b1, 3'd4, 32'h44, 1'b1};
      tbl[5] = '{1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, SKID, 1'b1, 3'd4, 32'h44, 1'b1};
      tbl[6] = '{1'b1, 3'd7, 32'h55, 32'h500, 5'd5, 1'b1, 1'b1, 1'b1, 3'd7, 32'h55, 1'b1};
      tbl[7] = '{1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0};
      tbl[8] = '{1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0};
      // reset with a valid, all-ones-ctrl input pending
      clrn = 1'b0;
      drive(1'b1, 3'b111, 32'hffff_ffff, 32'hffff_ffff, 5'h1f, 1'b0);
      step();
      chk("rst_ov", out_valid, 0);
      chk("rst_ctrl", out_ctrl, 0);
      chk("rst_alu", out_alu, 0);
      chk("rst_b", out_b, 0);
      chk("rst_rn", out_rn, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_rdy", in_ready, 1);
      clrn = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].iv, tbl[i].ctrl, tbl[i].alu, tbl[i].b, tbl[i].rn, tbl[i].ordy);
         #1;
         chk($sformatf("rdy[%0d]", i), in_ready, tbl[i].exp_rdy);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL sb_underflow[%0d]: got output alu %0h expected none", i, out_alu);
            end else begin
               p = sb.pop_front();
               chk($sformatf("sb_alu[%0d]", i), out_alu, p.alu);
               chk($sformatf("sb_b[%0d]", i), out_b, p.b);
               chk($sformatf("sb_rn[%0d]", i), out_rn, p.rn);
               chk($sformatf("sb_ctrl[%0d]", i), out_ctrl, p.ctrl);
            end
         end
         if (tbl[i].iv && tbl[i].exp_rdy) sb.push_back('{tbl[i].ctrl, tbl[i].alu, tbl[i].b, tbl[i].rn});
         step();
         chk($sformatf("ov[%0d]", i), out_valid, tbl[i].exp_ov);
         chk($sformatf("ctrl[%0d]", i), out_ctrl, tbl[i].exp_ctrl);
         if (tbl[i].chk_alu) chk($sformatf("alu[%0d]", i), out_alu, tbl[i].exp_alu);
      end
      chk("sb_empty", sb.size(), 0);
      // backpressure: stall count and saturation on the 2-bit instance
      clrn = 1'b0; step(); clrn = 1'b1;
      drive(1'b1, 3'd3, 32'h77, 32'h99, 5'd9, 1'b0);
      step();
      chk("bp_ov", out_valid, 1);
      drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("bp_alu[%0d]", k), out_alu, 32'h77);
         chk($sformatf("bp_rn[%0d]", k), out_rn, 9);
         chk($sformatf("bp_stall[%0d]", k), stall_cnt, k + 1);
      end
      chk("bp_sat", stall_cnt2, 3);
      // reset in the middle of a stall
      clrn = 1'b0; step(); clrn = 1'b1;
      chk("rs_stall", stall_cnt, 0);
      chk("rs_stall2", stall_cnt2, 0);
      chk("rs_ov", out_valid, 0);
      chk("rs_rn", out_rn, 0);
      // flush drops held and incoming, keeps data fields
      drive(1'b1, 3'b101, 32'h123, 32'habc, 5'd7, 1'b0);
      step();
      chk("fl_pre_ctrl", out_ctrl, 3'b101);
      flush = 1'b1;
      drive(1'b1, 3'b011, 32'h456, 32'h0, 5'd2, 1'b0);
      step();
      flush = 1'b0;
      chk("fl_ov", out_valid, 0);
      chk("fl_ctrl", out_ctrl, 0);
      chk("fl_rn", out_rn, 7);
      chk("fl_alu", out_alu, 32'h123);
      drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
      step();
      chk("fl_nocap", out_valid, 0);
      chk("fl_stall", stall_cnt, 1);
      drive(1'b1, 3'b001, 32'h9, 32'h0, 5'd3, 1'b1);
      step();
      flush = 1'b1;
      drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b1);
      #1;
      chk("flr_take_ov", out_valid, 1);
      chk("flr_take_alu", out_alu, 32'h9);
      step();
      flush = 1'b0;
      chk("flr_empty", out_valid, 0);
`ifdef PIPE_STAGE_SKID_EN
      drive(1'b1, 3'd1, 32'hA, 32'h0, 5'd1, 1'b0);
      step();
      drive(1'b1, 3'd1, 32'hB, 32'h0, 5'd2, 1'b0);
      step();
      chk("sk_rdy", in_ready, 0);
      chk("sk_alu0", out_alu, 32'hA);
      drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b1);
      step();
      chk("sk_ov1", out_valid, 1);
      chk("sk_alu1", out_alu, 32'hB);
      chk("sk_rdy1", in_ready, 1);
      step();
      chk("sk_empty", out_valid, 0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
